// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read path: widths, the
// hard-wired zero register and the response-buffer occupancy encoding.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO. Occupancy is tracked by an explicit state
// machine; the pointers only select storage slots.
module rsp_fifo2 #(
    parameter int unsigned W = regfile_pkg::ADDR_W + regfile_pkg::DATA_W
) (
    input  logic         clock,
    input  logic         clr_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    import regfile_pkg::*;

    occ_e         state_q, state_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (state_q != FULL);
    assign do_pop  = pop && (state_q != EMPTY);

    // Next-state: slot writes, pointer advance and occupancy transitions.
    // Push+pop in ONE advances both pointers, so the new entry becomes head.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case (state_q)
            EMPTY: if (do_push) state_d = ONE;
            ONE: begin
                if (do_push && !do_pop)      state_d = FULL;
                else if (do_pop && !do_push) state_d = EMPTY;
            end
            FULL:  if (do_pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy state, pointers and storage; clear discards all entries.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (state_q == FULL);
    assign empty = (state_q == EMPTY);

endmodule

// File: rtl/regfile_read_port.sv
// Register-file read front-end: valid/ready request, combinational RF
// address, write-to-read forwarding, r0 forced to zero, and a two-entry
// response buffer so consumers can stall without losing reads.
module regfile_read_port #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clr_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [CNT_W-1:0]  rd_count
);
    import regfile_pkg::*;

    logic                     accept;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_W-1:0]        cap_data;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    assign rf_addr   = req_addr;
    assign req_ready = !fifo_full;
    assign rsp_valid = !fifo_empty;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Value captured at accept: r0 reads zero, a same-cycle write to the
    // requested register wins over the stale register-file value.
    always_comb begin
        cap_data = rf_data;
        if (req_addr == ADDR_W'(ZERO_REG)) begin
            cap_data = '0;
        end else if (wr_en && (wr_addr == req_addr)) begin
            cap_data = wr_data;
        end
    end

    // Accepted-request counter, wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign rd_count = cnt_q;

    rsp_fifo2 #(
        .W(ADDR_W + DATA_W)
    ) u_fifo (
        .clock     (clock),
        .clr_n     (clr_n),
        .push      (accept),
        .push_data ({req_addr, cap_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {rsp_addr, rsp_data} = head;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: a behavioural register file feeds rf_data,
// expected responses are queued at accept and matched against popped ones.
module tb_regfile_read_port;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef logic [AW+DW-1:0] ent_t;

    logic          clock;
    logic          clr_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic [CW-1:0] rd_count;

    logic [DW-1:0] rf_mem [32];
    assign rf_data = rf_mem[rf_addr];

    ent_t          exp_q[$];
    ent_t          got_q[$];
    logic [CW-1:0] cnt_model;
    int            n_tests;
    int            n_fail;

    regfile_read_port #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .clock    (clock),
        .clr_n    (clr_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_addr (rsp_addr),
        .rd_count (rd_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock: record accept (with expected value) and pop before the edge,
    // apply the register-file write at the edge, return 1 unit after it.
    task automatic tick();
        logic [DW-1:0] e;
        if (req_valid && req_ready) begin
            if (req_addr == '0)                           e = '0;
            else if (wr_en && wr_addr == req_addr)        e = wr_data;
            else                                          e = rf_mem[req_addr];
            exp_q.push_back({req_addr, e});
            cnt_model = cnt_model + 1'b1;
        end
        if (rsp_valid && rsp_ready) got_q.push_back({rsp_addr, rsp_data});
        @(posedge clock);
        if (wr_en && wr_addr != '0) rf_mem[wr_addr] = wr_data;
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        #2;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %0b want 1", req_ready); end
        n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
        n_tests++; if (rsp_addr !== 5'h0) begin n_fail++; $display("FAIL rst_rsp_addr got %h want 0", rsp_addr); end
        n_tests++; if (rd_count !== 4'h0) begin n_fail++; $display("FAIL rst_rd_count got %h want 0", rd_count); end
        tick();
        clr_n = 1'b1;
        tick();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready got %0b want 1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rsp_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_basic();
        ent_t g, e;
        rf_mem[5] = 32'h0000_0019;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 5'd5;
        n_tests++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL rf_addr got %h want 05", rf_addr); end
        tick();
        req_valid = 1'b0;
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", rsp_valid); end
        n_tests++; if (rsp_addr !== 5'd5) begin n_fail++; $display("FAIL basic_addr got %h want 05", rsp_addr); end
        n_tests++; if (rsp_data !== 32'h19) begin n_fail++; $display("FAIL basic_data got %h want 00000019", rsp_data); end
        n_tests++; if (rd_count !== 4'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", rd_count); end
        tick();
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %0b want 0", rsp_valid); end
        while (got_q.size() != 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL basic_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_forward();
        ent_t g, e;
        rf_mem[7] = 32'h19;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1C;
        tick();
        n_tests++; if (rsp_data !== 32'h1C) begin n_fail++; $display("FAIL fwd_hit got %h want 0000001c", rsp_data); end
        rf_mem[7] = 32'h19;
        wr_addr = 5'd6;
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        n_tests++; if (rsp_data !== 32'h19) begin n_fail++; $display("FAIL fwd_miss got %h want 00000019", rsp_data); end
        tick();
        while (got_q.size() != 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL fwd_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_zero();
        ent_t g, e;
        rf_mem[0] = 32'hFFFF_FFFF;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL zero_reg got %h want 00000000", rsp_data); end
        tick();
        while (got_q.size() != 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL zero_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        ent_t g, e;
        logic [CW-1:0] c0;
        rf_mem[1] = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h33;
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 5'd1; tick();
        req_addr = 5'd2; tick();
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %0b want 0", req_ready); end
        req_addr = 5'd3;
        c0 = rd_count;
        tick();
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full got %0b want 0", req_ready); end
        n_tests++; if (rd_count !== c0) begin n_fail++; $display("FAIL bp_no_accept got %0d want %0d", rd_count, c0); end
        n_tests++; if (rsp_addr !== 5'd1 || rsp_data !== 32'h11) begin n_fail++; $display("FAIL bp_hold got %h/%h want 01/00000011", rsp_addr, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_bubble_ready got %0b want 1", req_ready); end
        n_tests++; if (rsp_addr !== 5'd2) begin n_fail++; $display("FAIL bp_second_head got %h want 02", rsp_addr); end
        tick();
        req_valid = 1'b0;
        n_tests++; if (rsp_addr !== 5'd3 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third_head got %h/%0b want 03/1", rsp_addr, rsp_valid); end
        n_tests++; if (rd_count !== cnt_model) begin n_fail++; $display("FAIL bp_count got %0d want %0d", rd_count, cnt_model); end
        tick();
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", rsp_valid); end
        n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL bp_pop_count got %0d want 3", got_q.size()); end
        while (got_q.size() != 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL bp_order got %h want %h", g, e); end
        end
    endtask

    task automatic test_snapshot();
        ent_t g, e;
        rf_mem[4] = 32'hA;
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5'd4;
        tick();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hB;
        tick();
        wr_en = 1'b0;
        tick();
        n_tests++; if (rsp_data !== 32'hA) begin n_fail++; $display("FAIL snapshot got %h want 0000000a", rsp_data); end
        rsp_ready = 1'b1;
        tick();
        while (got_q.size() != 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL snap_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        ent_t g, e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'($urandom_range(0, 31));
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = (i % 3 == 0) ? req_addr : AW'($urandom_range(0, 31));
            wr_data   = $urandom;
            n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, req_ready); end
            tick();
            n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %0b want 1", i, rsp_valid); end
            n_tests++; if (rd_count !== cnt_model) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, rd_count, cnt_model); end
        end
        req_valid = 1'b0; wr_en = 1'b0;
        tick();
        while (got_q.size() != 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_sb got %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        rf_mem[8] = 32'h88; rf_mem[9] = 32'h99;
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 5'd8; tick();
        req_addr = 5'd9; tick();
        req_valid = 1'b0;
        n_tests++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre got %0b/%0b want 1/0", rsp_valid, req_ready); end
        #2 clr_n = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got %0b want 0", rsp_valid); end
        n_tests++; if (rd_count !== 4'd0) begin n_fail++; $display("FAIL mid_rd_count got %0d want 0", rd_count); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_req_ready got %0b want 1", req_ready); end
        @(posedge clock); #1;
        clr_n = 1'b1;
        exp_q.delete(); got_q.delete(); cnt_model = '0;
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++; if (got_q.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %0d pops/valid %0b want 0/0", got_q.size(), rsp_valid); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cnt_model = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_basic();
        test_forward();
        test_zero();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
